io_port: RTL and testbench

- Peripheral I/O stage between the CPU core's in/out port signals and the external world.
- Output side: buffers words the CPU writes (out_signal/out_data pulses) in a FIFO and drains them to a downstream sink over valid/ready.
- Input side: a 1-entry holding register accepts words from an upstream source over valid/ready and presents the current word to the CPU's in_data, advancing when the CPU signals consumption.

---
 rtl/io_port.sv | 124 ++++++++++++
 tb/tb_io_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_port.sv
`default_nettype none
// ============================================================================
//  Module   : io_port
//  Purpose  : CPU I/O stage. CPU writes go out through a FWFT FIFO; words
//             arriving from upstream are held one at a time for the CPU.
//  Revision : 1.0 - initial release
// ============================================================================
module io_port #(
    parameter int OUT_DEPTH = 8,
    parameter int DATA_W    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_out_signal,
    input  logic [DATA_W-1:0]            cpu_out_data,
    input  logic                         cpu_in_signal,
    output logic [DATA_W-1:0]            cpu_in_data,
    output logic                         cpu_in_valid,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         out_overflow,
    output logic                         in_underflow
);

    localparam int c_PTR_W = $clog2(OUT_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(OUT_DEPTH);

    logic [DATA_W-1:0]  r_mem [OUT_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_valid;
    logic               r_underflow;
    logic               r_out_sig_q;
    logic               r_in_sig_q;

    logic w_push;
    logic w_consume;
    logic w_full;
    logic w_pop;
    logic w_wr_en;
    logic w_load;

    // Strobes are level signals from the CPU; only their rising edge is an event.
    assign w_push    = cpu_out_signal & ~r_out_sig_q;
    assign w_consume = cpu_in_signal  & ~r_in_sig_q;

    assign w_full    = (r_count == c_FULL);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_count = r_count;

    assign in_ready     = ~r_hold_valid | w_consume;
    assign w_load       = in_valid & in_ready;
    assign cpu_in_valid = r_hold_valid;
    assign cpu_in_data  = r_hold;
    assign out_overflow = r_overflow;
    assign in_underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr] <= cpu_out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_underflow  <= 1'b0;
            r_out_sig_q  <= 1'b0;
            r_in_sig_q   <= 1'b0;
        end else begin
            r_out_sig_q <= cpu_out_signal;
            r_in_sig_q  <= cpu_in_signal;

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end

            if (w_consume && !r_hold_valid) begin
                r_underflow <= 1'b1;
            end
            // Holding register reads as zero whenever it is empty.
            if (w_load) begin
                r_hold       <= in_data;
                r_hold_valid <= 1'b1;
            end else if (w_consume && r_hold_valid) begin
                r_hold       <= '0;
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port
//  Purpose  : Self-checking bench for io_port against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_port;

    localparam int OUT_DEPTH = 8;
    localparam int DATA_W    = 64;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       cpu_out_signal;
    logic [DATA_W-1:0]          cpu_out_data;
    logic                       cpu_in_signal;
    logic [DATA_W-1:0]          cpu_in_data;
    logic                       cpu_in_valid;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_ready;
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_ready;
    logic [$clog2(OUT_DEPTH):0] out_count;
    logic                       out_overflow;
    logic                       in_underflow;

    io_port #(.OUT_DEPTH(OUT_DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_out_signal (cpu_out_signal),
        .cpu_out_data   (cpu_out_data),
        .cpu_in_signal  (cpu_in_signal),
        .cpu_in_data    (cpu_in_data),
        .cpu_in_valid   (cpu_in_valid),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_count      (out_count),
        .out_overflow   (out_overflow),
        .in_underflow   (in_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: FIFO as a queue, holding register as value + flag.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_hold = '0;
    bit m_hold_v = 0, m_ovf = 0, m_unf = 0, m_out_prev = 0, m_in_prev = 0;

    always @(posedge clk) begin
        bit push, consume, pop, full, rdy;
        logic [DATA_W-1:0] dropped;
        if (reset) begin
            mq.delete();
            m_hold = '0; m_hold_v = 0; m_ovf = 0; m_unf = 0;
            m_out_prev = 0; m_in_prev = 0;
        end else begin
            push    = cpu_out_signal && !m_out_prev;
            consume = cpu_in_signal && !m_in_prev;
            full    = (mq.size() == OUT_DEPTH);
            pop     = (mq.size() != 0) && out_ready;
            if (pop) dropped = mq.pop_front();
            if (push) begin
                if (!full || pop) mq.push_back(cpu_out_data);
                else m_ovf = 1;
            end
            rdy = !m_hold_v || consume;
            if (consume && !m_hold_v) m_unf = 1;
            if (in_valid && rdy) begin
                m_hold = in_data; m_hold_v = 1;
            end else if (consume) begin
                m_hold = '0; m_hold_v = 0;
            end
            m_out_prev = cpu_out_signal;
            m_in_prev  = cpu_in_signal;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid",    64'(out_valid),    64'(mq.size() != 0));
            chk("out_data",     out_data,          (mq.size() != 0) ? mq[0] : '0);
            chk("out_count",    64'(out_count),    64'(mq.size()));
            chk("out_overflow", 64'(out_overflow), 64'(m_ovf));
            chk("cpu_in_valid", 64'(cpu_in_valid), 64'(m_hold_v));
            chk("cpu_in_data",  cpu_in_data,       m_hold);
            chk("in_ready",     64'(in_ready),     64'(!m_hold_v || (cpu_in_signal && !m_in_prev)));
            chk("in_underflow", 64'(in_underflow), 64'(m_unf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        cpu_out_signal = 1; cpu_out_data = d; tick();
        cpu_out_signal = 0; tick();
    endtask

    initial begin
        reset = 1; cpu_out_signal = 0; cpu_out_data = '0; cpu_in_signal = 0;
        out_ready = 0; in_valid = 0; in_data = '0;
        tick(); tick();
        check_en = 1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 0; tick();

        // Single push then pop
        cpu_out_signal = 1; cpu_out_data = 64'hDEAD; tick();
        cpu_out_signal = 0;
        chk("lit_push_valid", 64'(out_valid), 64'd1);
        chk("lit_push_data",  out_data,       64'hDEAD);
        chk("lit_push_count", 64'(out_count), 64'd1);
        out_ready = 1; tick();
        chk("lit_pop_valid", 64'(out_valid), 64'd0);
        chk("lit_pop_count", 64'(out_count), 64'd0);
        out_ready = 0;

        // Overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) push_word(64'(i));
        chk("lit_ovf_count", 64'(out_count),    64'd8);
        chk("lit_ovf_flag",  64'(out_overflow), 64'd1);
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("lit_drain_order", out_data, 64'(i));
            tick();
        end
        chk("lit_drain_empty", 64'(out_valid), 64'd0);
        out_ready = 0;

        // Push while full with simultaneous pop
        for (int i = 0; i < 8; i++) push_word(64'h100 + 64'(i));
        cpu_out_signal = 1; cpu_out_data = 64'h55; out_ready = 1; tick();
        cpu_out_signal = 0; out_ready = 0;
        chk("lit_fullpop_count", 64'(out_count), 64'd8);
        out_ready = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("lit_last_word", out_data, 64'h55);
        tick();
        out_ready = 0;

        // Push/pop across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cpu_out_signal = (i % 2 == 0);
            cpu_out_data   = {$urandom, $urandom};
            out_ready      = 1'($urandom);
            tick();
        end
        cpu_out_signal = 0; out_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 0;

        // Held strobe counts once
        cpu_out_signal = 1; cpu_out_data = 64'h7;
        for (int i = 0; i < 4; i++) tick();
        cpu_out_signal = 0; tick();
        chk("lit_held_count", 64'(out_count), 64'd1);
        out_ready = 1; tick(); out_ready = 0;

        // Input holding register
        in_valid = 1; in_data = 64'h11; tick();
        chk("lit_in_valid",  64'(cpu_in_valid), 64'd1);
        chk("lit_in_data",   cpu_in_data,       64'h11);
        chk("lit_in_ready0", 64'(in_ready),     64'd0);
        in_data = 64'h22; cpu_in_signal = 1; tick();
        cpu_in_signal = 0; in_valid = 0;
        chk("lit_replace_data",  cpu_in_data,       64'h22);
        chk("lit_replace_valid", 64'(cpu_in_valid), 64'd1);
        tick();
        cpu_in_signal = 1; tick(); cpu_in_signal = 0;
        chk("lit_consume_valid", 64'(cpu_in_valid), 64'd0);
        chk("lit_consume_data",  cpu_in_data,       64'd0);
        tick();
        cpu_in_signal = 1; tick(); cpu_in_signal = 0;
        chk("lit_underflow", 64'(in_underflow), 64'd1);
        tick();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) push_word(64'hA0 + 64'(i));
        in_valid = 1; in_data = 64'h33; tick(); in_valid = 0;
        reset = 1; out_ready = 1; in_valid = 1; tick();
        reset = 0; out_ready = 0; in_valid = 0;
        chk("lit_rst_count", 64'(out_count),    64'd0);
        chk("lit_rst_valid", 64'(out_valid),    64'd0);
        chk("lit_rst_inv",   64'(cpu_in_valid), 64'd0);
        chk("lit_rst_ovf",   64'(out_overflow), 64'd0);
        chk("lit_rst_unf",   64'(in_underflow), 64'd0);
        chk("lit_rst_rdy",   64'(in_ready),     64'd1);

        // Random traffic on both sides with occasional reset
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 59) == 0);
            cpu_out_signal = 1'($urandom);
            cpu_out_data   = {$urandom, $urandom};
            cpu_in_signal  = 1'($urandom);
            out_ready      = ($urandom_range(0, 3) == 0);
            in_valid       = 1'($urandom);
            in_data        = {$urandom, $urandom};
            tick();
        end
        reset = 0; cpu_out_signal = 0; cpu_in_signal = 0; in_valid = 0; out_ready = 1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
